// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - shared fetch FSM states, reset PC and MIPS opcode constants
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] J      = 6'h02;
  localparam logic [5:0] JAL    = 6'h03;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2b;

  // Branch displacement in bytes: sign-extended word offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - imem request/response and decode-side handshake bundle
// master = fetch unit, slave = imem plus decode/control environment.
interface instr_fetch_unit_if #(parameter int CNT_W = 32);
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic [31:0]      instr;
  logic [5:0]       op;
  logic [31:0]      pc_out;
  logic [31:0]      pc_plus4;
  logic             instr_valid;
  logic             instr_ready;
  logic             ctl_jump;
  logic             ctl_branch_eq;
  logic             ctl_branch_ne;
  logic             alu_zero;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output imem_req, imem_addr, instr, op, pc_out, pc_plus4, instr_valid, instr_count,
    input  imem_ack, imem_rdata, instr_ready, ctl_jump, ctl_branch_eq, ctl_branch_ne, alu_zero
  );

  modport slave (
    input  imem_req, imem_addr, instr, op, pc_out, pc_plus4, instr_valid, instr_count,
    output imem_ack, imem_rdata, instr_ready, ctl_jump, ctl_branch_eq, ctl_branch_ne, alu_zero
  );
endinterface

// File: rtl/instr_fetch_unit_next_pc.sv
// rtl/instr_fetch_unit_next_pc.sv - combinational link/target adders and redirect decision
module fetch_next_pc
  import mips_fetch_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  input  logic        i_jump,
  input  logic        i_branch_eq,
  input  logic        i_branch_ne,
  input  logic        i_alu_zero,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_target,
  output logic        o_taken
);
  logic [31:0] w_jump_target;
  logic [31:0] w_branch_target;
  logic        w_branch_taken;

  assign o_pc_plus4      = i_pc + 32'd4;
  assign w_jump_target   = {o_pc_plus4[31:28], i_instr[25:0], 2'b00};
  assign w_branch_target = o_pc_plus4 + branch_offset(i_instr[15:0]);
  assign w_branch_taken  = (i_branch_eq & i_alu_zero) | (i_branch_ne & ~i_alu_zero);

  // Jump outranks a simultaneous branch request.
  assign o_target = i_jump ? w_jump_target : w_branch_target;
  assign o_taken  = i_jump | w_branch_taken;
endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - MIPS fetch FSM: imem request, held instruction, next-PC, retire count
// MIPS_DELAY_SLOT_EN: taken redirects are deferred by one (delay-slot) instruction.
module instr_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  bus
);
  fetch_state_t     r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic             r_req;
  logic             r_valid;
  logic [CNT_W-1:0] r_count;

  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_target;
  logic             w_taken;
  logic [31:0]      w_next_pc;
  logic             w_accept;

  fetch_next_pc u_next_pc (
    .i_pc        (r_pc),
    .i_instr     (r_instr),
    .i_jump      (bus.ctl_jump),
    .i_branch_eq (bus.ctl_branch_eq),
    .i_branch_ne (bus.ctl_branch_ne),
    .i_alu_zero  (bus.alu_zero),
    .o_pc_plus4  (w_pc_plus4),
    .o_target    (w_target),
    .o_taken     (w_taken)
  );

  assign w_accept = (r_state == HOLD) & bus.instr_ready;

`ifdef MIPS_DELAY_SLOT_EN
  logic        r_pend;
  logic [31:0] r_pend_pc;

  // The delay-slot instruction always runs; its own redirect request is dropped.
  assign w_next_pc = r_pend ? r_pend_pc : w_pc_plus4;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pend    <= 1'b0;
      r_pend_pc <= 32'd0;
    end else if (w_accept) begin
      if (r_pend) begin
        r_pend <= 1'b0;
      end else if (w_taken) begin
        r_pend    <= 1'b1;
        r_pend_pc <= w_target;
      end
    end
  end
`else
  assign w_next_pc = w_taken ? w_target : w_pc_plus4;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_pc    <= {RESET_PC[31:2], 2'b00};
      r_instr <= 32'd0;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        // IDLE absorbs any ack still in flight from before reset.
        IDLE: begin
          r_state <= FETCH;
          r_req   <= 1'b1;
        end
        FETCH: begin
          if (bus.imem_ack) begin
            r_instr <= bus.imem_rdata;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_accept) begin
            r_valid <= 1'b0;
            r_count <= r_count + CNT_W'(1);
            r_pc    <= w_next_pc;
            r_req   <= 1'b1;
            r_state <= FETCH;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_pc;
  assign bus.instr       = r_instr;
  assign bus.op          = r_instr[31:26];
  assign bus.pc_out      = r_pc;
  assign bus.pc_plus4    = w_pc_plus4;
  assign bus.instr_valid = r_valid;
  assign bus.instr_count = r_count;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
  import mips_fetch_pkg::*;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.CNT_W(32)) bus();

  instr_fetch_unit #(.RESET_PC(RPC), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_count;
  logic        m_pend;
  logic [31:0] m_pend_pc;

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w,
                                             input bit j, input bit beq, input bit bne,
                                             input bit z, output bit taken);
    logic [31:0] link;
    int          disp;
    link = pc + 32'd4;
    taken = 1'b0;
    if (j) begin
      taken = 1'b1;
      return {link[31:28], w[25:0], 2'b00};
    end
    if ((beq && z) || (bne && !z)) begin
      taken = 1'b1;
      disp = int'($signed(w[15:0])) * 4;
      return link + 32'(disp);
    end
    return link;
  endfunction

  task automatic idle_inputs();
    bus.imem_ack      = 1'b0;
    bus.imem_rdata    = 32'd0;
    bus.instr_ready   = 1'b0;
    bus.ctl_jump      = 1'b0;
    bus.ctl_branch_eq = 1'b0;
    bus.ctl_branch_ne = 1'b0;
    bus.alu_zero      = 1'b0;
  endtask

  task automatic do_reset(input int cycles, input bit noisy_ack);
    @(negedge clk);
    reset = 1'b0;
    if (noisy_ack) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
    end
    repeat (cycles) @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    m_pc = RPC;
    m_count = 32'd0;
    m_pend = 1'b0;
    m_pend_pc = 32'd0;
  endtask

  task automatic serve(input logic [31:0] word, input int delay, input bit early,
                       output logic [31:0] addr);
    int n = 0;
    while (bus.imem_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL req_timeout req=%b required=1", bus.imem_req);
    end
    addr = bus.imem_addr;
    if (early) begin
      bus.instr_ready   = 1'b1;
      bus.ctl_jump      = 1'($urandom);
      bus.ctl_branch_eq = 1'($urandom);
      bus.ctl_branch_ne = 1'($urandom);
      bus.alu_zero      = 1'($urandom);
    end
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== addr) begin
        errors++;
        $display("FAIL addr_stable req=%b addr=%h required req=1 addr=%h",
                 bus.imem_req, bus.imem_addr, addr);
      end
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== word) begin
      errors++;
      $display("FAIL capture valid=%b instr=%h required valid=1 instr=%h",
               bus.instr_valid, bus.instr, word);
    end
  endtask

  task automatic accept(input bit j, input bit beq, input bit bne, input bit z);
    bus.instr_ready   = 1'b1;
    bus.ctl_jump      = j;
    bus.ctl_branch_eq = beq;
    bus.ctl_branch_ne = bne;
    bus.alu_zero      = z;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic step(input logic [31:0] word, input int delay, input bit early,
                      input bit j, input bit beq, input bit bne, input bit z);
    logic [31:0] a;
    logic [31:0] nxt;
    bit          tk;
    serve(word, delay, early, a);
    checks++;
    if (a !== m_pc) begin
      errors++;
      $display("FAIL fetch_addr addr=%h required=%h", a, m_pc);
    end
    checks++;
    if (bus.op !== word[31:26] || bus.pc_out !== m_pc || bus.pc_plus4 !== m_pc + 32'd4) begin
      errors++;
      $display("FAIL held_fields op=%h pc_out=%h pc_plus4=%h required op=%h pc_out=%h pc_plus4=%h",
               bus.op, bus.pc_out, bus.pc_plus4, word[31:26], m_pc, m_pc + 32'd4);
    end
    accept(j, beq, bne, z);
    nxt = model_next(m_pc, word, j, beq, bne, z, tk);
`ifdef MIPS_DELAY_SLOT_EN
    if (m_pend) begin
      m_pc = m_pend_pc;
      m_pend = 1'b0;
    end else if (tk) begin
      m_pend_pc = nxt;
      m_pend = 1'b1;
      m_pc = m_pc + 32'd4;
    end else begin
      m_pc = nxt;
    end
`else
    m_pc = nxt;
`endif
    m_count = m_count + 32'd1;
    checks++;
    if (bus.instr_count !== m_count || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_accept count=%0d valid=%b required count=%0d valid=0",
               bus.instr_count, bus.instr_valid, m_count);
    end
  endtask

  task automatic test_reset();
    do_reset(2, 1'b1);
    checks++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instr !== 32'd0 ||
        bus.instr_count !== 32'd0 || bus.imem_addr !== RPC) begin
      errors++;
      $display("FAIL reset_state req=%b valid=%b instr=%h count=%0d addr=%h required 0 0 0 0 %h",
               bus.imem_req, bus.instr_valid, bus.instr, bus.instr_count, bus.imem_addr, RPC);
    end
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_req req=%b valid=%b required req=1 valid=0",
               bus.imem_req, bus.instr_valid);
    end
    checks++;
    if (bus.instr_count !== 32'd0) begin
      errors++;
      $display("FAIL count_before_accept count=%0d required=0", bus.instr_count);
    end
    step({R_TYPE, 26'h0012345}, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_sequential();
    int delays[3] = '{0, 3, 0};
    do_reset(2, 1'b0);
    foreach (delays[i]) step({LW, 26'($urandom)}, delays[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.instr_count !== 32'd3 || bus.imem_addr !== 32'h0040_000C) begin
      errors++;
      $display("FAIL sequential count=%0d addr=%h required count=3 addr=0040000c",
               bus.instr_count, bus.imem_addr);
    end
  endtask

`ifndef MIPS_DELAY_SLOT_EN
  task automatic test_branch();
    do_reset(2, 1'b0);
    repeat (4) step({R_TYPE, 26'd0}, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step({BEQ, 5'd1, 5'd1, 16'hFFFF}, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (bus.imem_addr !== 32'h0040_0010) begin
      errors++;
      $display("FAIL beq_taken addr=%h required=00400010", bus.imem_addr);
    end
    step({BEQ, 5'd1, 5'd2, 16'hFFFF}, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.imem_addr !== 32'h0040_0014) begin
      errors++;
      $display("FAIL beq_not_taken addr=%h required=00400014", bus.imem_addr);
    end
  endtask

  task automatic test_jump();
    do_reset(2, 1'b0);
    repeat (8) step({R_TYPE, 26'd0}, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step({J, 26'h010_0008}, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (bus.imem_addr !== 32'h0040_0020) begin
      errors++;
      $display("FAIL jump_priority addr=%h required=00400020", bus.imem_addr);
    end
  endtask
`else
  task automatic test_delay_slot();
    do_reset(2, 1'b0);
    step({BNE, 5'd1, 5'd2, 16'h003F}, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.imem_addr !== 32'h0040_0004) begin
      errors++;
      $display("FAIL delay_slot_addr addr=%h required=00400004", bus.imem_addr);
    end
    step({J, 26'h000_0000}, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.imem_addr !== 32'h0040_0100) begin
      errors++;
      $display("FAIL delay_slot_target addr=%h required=00400100", bus.imem_addr);
    end
  endtask
`endif

  task automatic test_reset_mid_fetch();
    do_reset(2, 1'b0);
    repeat (2) step({SW, 26'($urandom)}, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== RPC) begin
      errors++;
      $display("FAIL reset_drops_req req=%b addr=%h required req=0 addr=%h",
               bus.imem_req, bus.imem_addr, RPC);
    end
    reset = 1'b1;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hBAD0_BAD0;
    m_pc = RPC;
    m_count = 32'd0;
    m_pend = 1'b0;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.instr !== 32'd0 || bus.imem_addr !== RPC) begin
      errors++;
      $display("FAIL stale_ack valid=%b instr=%h addr=%h required valid=0 instr=0 addr=%h",
               bus.instr_valid, bus.instr, bus.imem_addr, RPC);
    end
    step({R_TYPE, 26'h3FF_FFFF}, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    do_reset(1, 1'b0);
    for (int i = 0; i < 60; i++) begin
      logic [31:0] w;
      w = $urandom;
      step(w, int'($urandom_range(0, 3)), 1'($urandom),
           ($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    test_reset();
    test_sequential();
`ifndef MIPS_DELAY_SLOT_EN
    test_branch();
    test_jump();
`else
    test_delay_slot();
`endif
    test_reset_mid_fetch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
